// File: rtl/shift_pkg.sv
// ============================================================================
//  Package     : shift_pkg
//  Description : Shared types and constants for the sequential shifter:
//                FSM state encoding and the per-cycle step sizes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Step sizes applied to the 5-bit remaining-count register.
    localparam logic [4:0] C_STEP_ONE  = 5'd1;
    localparam logic [4:0] C_STEP_FOUR = 5'd4;

endpackage : shift_pkg

`default_nettype wire

// File: rtl/proc_define.sv
// ============================================================================
//  Module      : (none)  proc_define.sv
//  Description : Processor-wide funct3 encodings shared by the execution
//                units.  Include-guarded so it can be pulled into several
//                files of the same compilation.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef PROC_DEFINE_SV
`define PROC_DEFINE_SV
`default_nettype none

`define FUNCT3_SLL     3'b001
`define FUNCT3_SRL_SRA 3'b101

`default_nettype wire
`endif

// File: rtl/shift_step.sv
// ============================================================================
//  Module      : shift_step
//  Description : One combinational shift step of 1 or 4 bit positions.
//  Ports       : i_data   - value to shift
//                i_left   - 1 = left shift, 0 = right shift
//                i_arith  - right shifts only: 1 = fill with i_data[31]
//                i_step4  - 1 = shift by 4, 0 = shift by 1
//                o_data   - shifted value
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_step (
    input  logic [31:0] i_data,
    input  logic        i_left,
    input  logic        i_arith,
    input  logic        i_step4,
    output logic [31:0] o_data
);

    logic w_fill;

    // Sign fill uses the MSB as it was before this step.
    assign w_fill = i_arith & i_data[31];

    always_comb begin
        o_data = i_data;
        if (i_left) begin
            o_data = i_step4 ? {i_data[27:0], 4'b0000} : {i_data[30:0], 1'b0};
        end else begin
            o_data = i_step4 ? {{4{w_fill}}, i_data[31:4]} : {w_fill, i_data[31:1]};
        end
    end

endmodule : shift_step

`default_nettype wire

// File: rtl/shift_seq.sv
// ============================================================================
//  Module      : shift_seq
//  Description : Multi-cycle SLL/SRL/SRA unit with valid/ready handshakes on
//                both sides and a kill input that aborts any operation.
//                Optional build macro SHIFT_SEQ_STEP4_EN enables 4-bit steps
//                while at least 4 positions remain.
//  Ports       : clk_i, rst_i            - clock, sync active-high reset
//                in_valid_i/in_ready_o   - request handshake
//                funct3_i, funct7_i      - operation select / arithmetic flag
//                op1_i, op2_i            - value, shift amount (op2_i[4:0])
//                kill_i                  - abort, overrides out_ready_i
//                out_valid_o/out_ready_i - result handshake
//                res_o                   - result (0 when not valid)
//                busy_o                  - FSM not idle
//  Revision    : 1.0  initial release
// ============================================================================
`include "proc_define.sv"
`default_nettype none

module shift_seq
    import shift_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  funct3_i,
    input  logic        funct7_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        kill_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] res_o,
    output logic        busy_o
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_data;
    logic [4:0]  r_count;
    logic [2:0]  r_funct3;
    logic        r_arith;

    logic        w_accept;
    logic        w_legal;
    logic        w_left;
    logic        w_step4;
    logic [4:0]  w_count_next;
    logic [31:0] w_step_data;
    logic        w_unused_op2;

    // Only the low five amount bits matter.
    assign w_unused_op2 = &{1'b0, op2_i[31:5]};

    assign in_ready_o  = (r_state == ST_IDLE) && !kill_i;
    assign w_accept    = in_valid_i && in_ready_o;
    assign w_legal     = (funct3_i == `FUNCT3_SLL) || (funct3_i == `FUNCT3_SRL_SRA);
    assign w_left      = (r_funct3 == `FUNCT3_SLL);

`ifdef SHIFT_SEQ_STEP4_EN
    assign w_step4 = (r_count >= C_STEP_FOUR);
`else
    assign w_step4 = 1'b0;
`endif

    assign w_count_next = r_count - (w_step4 ? C_STEP_FOUR : C_STEP_ONE);

    shift_step u_shift_step (
        .i_data  (r_data),
        .i_left  (w_left),
        .i_arith (r_arith),
        .i_step4 (w_step4),
        .o_data  (w_step_data)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Zero amount or illegal op: result is op1 as latched.
                    w_state_next = ((op2_i[4:0] == 5'd0) || !w_legal) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (kill_i) begin
                    w_state_next = ST_IDLE;
                end else if (w_count_next == 5'd0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (kill_i || out_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_data   <= 32'd0;
            r_count  <= 5'd0;
            r_funct3 <= 3'd0;
            r_arith  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_data   <= op1_i;
                r_count  <= op2_i[4:0];
                r_funct3 <= funct3_i;
                r_arith  <= funct7_i;
            end else if (r_state == ST_SHIFT) begin
                r_data  <= w_step_data;
                r_count <= w_count_next;
            end
        end
    end

    assign out_valid_o = (r_state == ST_DONE);
    assign res_o       = out_valid_o ? r_data : 32'd0;
    assign busy_o      = (r_state != ST_IDLE);

endmodule : shift_seq

`default_nettype wire

// File: tb/tb_shift_seq.sv
// ============================================================================
//  Module      : tb_shift_seq
//  Description : Directed self-checking bench for shift_seq.  Expected
//                latencies follow the step rule of the build (macro
//                SHIFT_SEQ_STEP4_EN when defined).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  funct3_i;
    logic        funct7_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        kill_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] res_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] c_sll = 3'b001;
    localparam logic [2:0] c_srx = 3'b101;

    shift_seq dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .kill_i      (kill_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .res_o       (res_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int shift_cycles(input int n);
`ifdef SHIFT_SEQ_STEP4_EN
        return n / 4 + n % 4;
`else
        return n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request, wait for out_valid_o, check latency and result.
    // Returns with DONE visible; the caller decides how it is drained.
    task automatic issue(input string tag, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
        int lat;
        in_valid_i = 1'b1;
        funct3_i   = f3;
        funct7_i   = f7;
        op1_i      = a;
        op2_i      = b;
        check_eq({tag, "_rdy"}, 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            tick();
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_res"}, res_o, exp_res);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        issue(tag, f3, f7, a, b, exp_res, exp_lat);
        tick();
        check_eq({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int vcount;
        rst_i = 1'b1; in_valid_i = 1'b0; funct3_i = 3'd0; funct7_i = 1'b0;
        op1_i = 32'd0; op2_i = 32'd0; kill_i = 1'b0; out_ready_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check_eq("rst_valid", 32'(out_valid_o), 32'd0);
        check_eq("rst_res",   res_o,            32'd0);
        check_eq("rst_busy",  32'(busy_o),      32'd0);
        check_eq("rst_ready", 32'(in_ready_o),  32'd1);

        run_op("sll31",  c_sll, 1'b0, 32'h0000_0001, 32'd31, 32'h8000_0000, 1 + shift_cycles(31));
        run_op("sra4",   c_srx, 1'b1, 32'h8000_0000, 32'd4,  32'hF800_0000, 1 + shift_cycles(4));
        run_op("srl4",   c_srx, 1'b0, 32'h8000_0000, 32'd4,  32'h0800_0000, 1 + shift_cycles(4));
        run_op("amt0",   c_sll, 1'b0, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1);
        run_op("amt1",   c_sll, 1'b0, 32'h1234_5678, 32'h21, 32'h2468_ACF0, 1 + shift_cycles(1));
        run_op("illegal",3'b000,1'b0, 32'hCAFE_F00D, 32'd5,  32'hCAFE_F00D, 1);
        run_op("sra7",   c_srx, 1'b1, 32'hF000_0000, 32'd7,  32'hFFE0_0000, 1 + shift_cycles(7));
        run_op("srapos", c_srx, 1'b1, 32'h7000_0000, 32'd8,  32'h0070_0000, 1 + shift_cycles(8));

        // Backpressure in DONE.
        out_ready_i = 1'b0;
        issue("bp", c_sll, 1'b0, 32'h3, 32'd2, 32'hC, 1 + shift_cycles(2));
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_valid", 32'(out_valid_o), 32'd1);
            check_eq("bp_res",   res_o,            32'hC);
            check_eq("bp_rdy",   32'(in_ready_o),  32'd0);
        end
        out_ready_i = 1'b1;
        tick();
        check_eq("bp_idle",  32'(busy_o),      32'd0);
        check_eq("bp_drop",  32'(out_valid_o), 32'd0);
        check_eq("bp_res0",  res_o,            32'd0);

        // Kill mid-SHIFT.
        in_valid_i = 1'b1; funct3_i = c_sll; funct7_i = 1'b0;
        op1_i = 32'h1; op2_i = 32'd20;
        tick();
        in_valid_i = 1'b0;
        tick();
        check_eq("kill_inshift", 32'(busy_o), 32'd1);
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check_eq("kill_idle", 32'(busy_o), 32'd0);
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid_o) vcount++;
            tick();
        end
        check_eq("kill_novalid", 32'(vcount), 32'd0);

        // Kill in DONE, overriding out_ready_i low.
        out_ready_i = 1'b0;
        issue("kdone", c_srx, 1'b0, 32'hF0, 32'd4, 32'h0F, 1 + shift_cycles(4));
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check_eq("kdone_valid", 32'(out_valid_o), 32'd0);
        check_eq("kdone_idle",  32'(busy_o),      32'd0);
        out_ready_i = 1'b1;

        // Kill with a request in IDLE blocks acceptance.
        kill_i = 1'b1; in_valid_i = 1'b1; op2_i = 32'd3;
        #1;
        check_eq("kidle_rdy", 32'(in_ready_o), 32'd0);
        tick();
        in_valid_i = 1'b0; kill_i = 1'b0;
        check_eq("kidle_busy", 32'(busy_o), 32'd0);

        // Reset mid-SHIFT.
        in_valid_i = 1'b1; funct3_i = c_sll; op1_i = 32'h1; op2_i = 32'd20;
        tick();
        in_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(out_valid_o), 32'd0);
        check_eq("mrst_res",   res_o,            32'd0);
        check_eq("mrst_busy",  32'(busy_o),      32'd0);
        check_eq("mrst_ready", 32'(in_ready_o),  32'd1);
        run_op("postrst", c_sll, 1'b0, 32'h3, 32'd2, 32'h0000_000C, 1 + shift_cycles(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_shift_seq

`default_nettype wire
